// File: rtl/regfile_operand_fetch_if.sv
// Handshake and register-file bus for the operand-fetch stage.
// The slave modport is the fetch stage; the master modport is its surroundings
// (upstream issue, register file read/writeback ports and downstream consumer).
interface regfile_operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [ADDR_W-1:0] rf_rdReg1;
  logic [ADDR_W-1:0] rf_rdReg2;
  logic [DATA_W-1:0] rf_rdData1;
  logic [DATA_W-1:0] rf_rdData2;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [DATA_W-1:0] out_op1;
  logic [DATA_W-1:0] out_op2;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  bypass_events;

  modport slave (
    input  in_valid, in_instr, rf_rdData1, rf_rdData2,
           wb_write, wb_reg, wb_data, out_ready,
    output in_ready, rf_rdReg1, rf_rdReg2,
           out_valid, out_instr, out_op1, out_op2, stall_cycles, bypass_events
  );

  modport master (
    output in_valid, in_instr, rf_rdData1, rf_rdData2,
           wb_write, wb_reg, wb_data, out_ready,
    input  in_ready, rf_rdReg1, rf_rdReg2,
           out_valid, out_instr, out_op1, out_op2, stall_cycles, bypass_events
  );
endinterface

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage: reads rs/rt from the register file, bypasses writebacks
// landing on the capture edge, and keeps a held entry coherent with later
// writebacks while the consumer stalls. One-entry output register.
module regfile_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic                  clock,
  input logic                  reset_n,
  regfile_operand_fetch_if.slave bus
);

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [DATA_W-1:0] out_op1_q, out_op1_d;
  logic [DATA_W-1:0] out_op2_q, out_op2_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bypass_q, bypass_d;

  logic [ADDR_W-1:0] rs_in, rt_in, rs_held, rt_held;
  logic              accept, hold;
  logic              cap_byp1, cap_byp2, ref_byp1, ref_byp2;
  logic [1:0]        bypass_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Register-file addresses go straight out of the incoming instruction.
  assign rs_in         = bus.in_instr[21 +: ADDR_W];
  assign rt_in         = bus.in_instr[16 +: ADDR_W];
  assign rs_held       = out_instr_q[21 +: ADDR_W];
  assign rt_held       = out_instr_q[16 +: ADDR_W];
  assign bus.rf_rdReg1 = rs_in;
  assign bus.rf_rdReg2 = rt_in;

  // Ready is the only path from out_ready; held low while in reset.
  assign bus.in_ready = reset_n & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign hold         = out_valid_q & ~bus.out_ready;

  // Next-state: capture with same-edge bypass, drain, or hold with writeback snoop.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    stall_d     = stall_q;
    cap_byp1    = bus.wb_write && (bus.wb_reg == rs_in) && (rs_in != '0);
    cap_byp2    = bus.wb_write && (bus.wb_reg == rt_in) && (rt_in != '0);
    ref_byp1    = bus.wb_write && (bus.wb_reg == rs_held) && (rs_held != '0);
    ref_byp2    = bus.wb_write && (bus.wb_reg == rt_held) && (rt_held != '0);
    bypass_inc  = 2'd0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = bus.in_instr;
      // $0 always reads as zero, even if something tries to write it.
      out_op1_d   = (rs_in == '0) ? '0 : (cap_byp1 ? bus.wb_data : bus.rf_rdData1);
      out_op2_d   = (rt_in == '0) ? '0 : (cap_byp2 ? bus.wb_data : bus.rf_rdData2);
      bypass_inc  = {1'b0, cap_byp1} + {1'b0, cap_byp2};
    end else if (hold) begin
      if (ref_byp1) out_op1_d = bus.wb_data;
      if (ref_byp2) out_op2_d = bus.wb_data;
      bypass_inc  = {1'b0, ref_byp1} + {1'b0, ref_byp2};
    end else if (out_valid_q) begin
      out_valid_d = 1'b0;
    end

    if (hold) stall_d = sat_add(stall_q, 2'd1);
    bypass_d = sat_add(bypass_q, bypass_inc);
  end

  // All stage state; reset discards any held entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      stall_q     <= '0;
      bypass_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      stall_q     <= stall_d;
      bypass_q    <= bypass_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_instr     = out_instr_q;
  assign bus.out_op1       = out_op1_q;
  assign bus.out_op2       = out_op2_q;
  assign bus.stall_cycles  = stall_q;
  assign bus.bypass_events = bypass_q;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for the operand-fetch stage. The bench plays the register file: its
// array is both the environment and the architectural reference. A delivered
// operand must equal the architectural value of its register at the moment
// the consumer takes it (zero for $0).
module tb_regfile_operand_fetch;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  regfile_operand_fetch_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();

  regfile_operand_fetch #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [31:0] regs [32];
  assign bus.rf_rdData1 = regs[bus.rf_rdReg1];
  assign bus.rf_rdData2 = regs[bus.rf_rdReg2];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic        m_valid = 1'b0;
  logic [31:0] m_held = '0;
  int          m_stall = 0;
  int          m_byp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int rs, input int rt);
    logic [4:0] a, b;
    a = rs[4:0];
    b = rt[4:0];
    return {6'd0, a, b, 10'd0, 6'h20};
  endfunction

  function automatic logic [31:0] arch(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : regs[idx];
  endfunction

  function automatic int hits(input logic [31:0] ins, input logic wbw, input logic [4:0] wbr);
    int n;
    n = 0;
    if (wbw && wbr != 0 && wbr == ins[25:21]) n++;
    if (wbw && wbr != 0 && wbr == ins[20:16]) n++;
    return n;
  endfunction

  task automatic preload();
    for (int k = 0; k < 32; k++) regs[k] = 10 * k;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    exp_q.delete();
    m_stall = 0;
    m_byp = 0;
  endtask

  // One clock: drive inputs, let the edge happen, then advance the reference.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    logic acc;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.wb_write  = wbw;
    bus.wb_reg    = wbr;
    bus.wb_data   = wbd;
    @(posedge clock);
    #1;
    if (reset_n) begin
      acc = v && (!m_valid || ordy);
      if (acc) begin
        exp_q.push_back(ins);
        m_held  = ins;
        m_byp   = m_byp + hits(ins, wbw, wbr);
        m_valid = 1'b1;
      end else if (m_valid && !ordy) begin
        m_stall = m_stall + 1;
        m_byp   = m_byp + hits(m_held, wbw, wbr);
      end else if (m_valid) begin
        m_valid = 1'b0;
      end
      if (m_stall > 65535) m_stall = 65535;
      if (m_byp > 65535) m_byp = 65535;
    end
    if (wbw && wbr != 0) regs[wbr] = wbd;
  endtask

  // Monitor: checks handshake state every cycle and scores each delivered entry.
  always @(negedge clock) begin
    if (reset_n) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!m_valid || bus.out_ready)});
      chk("stall_cycles", {16'd0, bus.stall_cycles}, m_stall);
      chk("bypass_events", {16'd0, bus.bypass_events}, m_byp);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [31:0] ins;
          ins = exp_q.pop_front();
          chk("out_instr", bus.out_instr, ins);
          chk("out_op1", bus.out_op1, arch(ins[25:21]));
          chk("out_op2", bus.out_op2, arch(ins[20:16]));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 0;
    bus.wb_write = 0; bus.wb_reg = 0; bus.wb_data = 0;
    preload();
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_op1", bus.out_op1, 32'd0);
    chk("rst_out_op2", bus.out_op2, 32'd0);
    chk("rst_stall", {16'd0, bus.stall_cycles}, 32'd0);
    chk("rst_bypass", {16'd0, bus.bypass_events}, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic fetch: reg[k] = 10k
    cycle(1, mk(3, 7), 1, 0, 0, 0);
    chk("fetch_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("fetch_op1", bus.out_op1, 32'd30);
    chk("fetch_op2", bus.out_op2, 32'd70);

    // Writes to $0 are ignored
    cycle(1, mk(0, 0), 1, 1, 0, 32'hDEAD);
    chk("zero_op1", bus.out_op1, 32'd0);
    chk("zero_op2", bus.out_op2, 32'd0);
    chk("zero_bypass", {16'd0, bus.bypass_events}, 32'd0);

    // Same-edge bypass
    cycle(1, mk(5, 6), 1, 1, 5, 32'h1234);
    chk("byp_op1", bus.out_op1, 32'h1234);
    chk("byp_op2", bus.out_op2, 32'd60);
    chk("byp_count", {16'd0, bus.bypass_events}, 32'd1);

    // Hold with refresh of rs==rt
    cycle(1, mk(9, 9), 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 9, 32'hBEEF);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("hold_op1", bus.out_op1, 32'hBEEF);
    chk("hold_op2", bus.out_op2, 32'hBEEF);
    chk("hold_stall", {16'd0, bus.stall_cycles}, 32'd4);
    chk("hold_bypass", {16'd0, bus.bypass_events}, 32'd3);
    chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    cycle(0, 0, 1, 0, 0, 0);

    // Back-to-back streaming
    preload();
    for (int k = 0; k < 16; k++) begin
      cycle(1, mk(k, 31 - k), 1, 0, 0, 0);
      chk("stream_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stream_op1", bus.out_op1, 10 * k);
      chk("stream_op2", bus.out_op2, 10 * (31 - k));
    end
    cycle(0, 0, 1, 0, 0, 0);

    // Randomized traffic with frequent register collisions
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, mk($urandom_range(0, 7), $urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
    end
    repeat (3) cycle(0, 0, 1, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 32'd0);

    // Reset in the middle of a stall
    cycle(1, mk(2, 3), 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_stall", {16'd0, bus.stall_cycles}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Stall counter saturation
    cycle(1, mk(4, 4), 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) cycle(0, 0, 0, 0, 0, 0);
    chk("stall_saturated", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
